// File: rtl/metropolis_judge.sv
// Metropolis acceptance judge for one replica.
// Accepts a proposed move iff delta <= 0 or beta*delta < -ln(r/2^32). The
// product is formed by a bit-serial shift-add multiplier and the log term by
// a leading-zero count plus a 16-entry mantissa LUT, both in Q.FRAC.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start             request pulse, taken only while idle
//   delta_dist        signed move delta (integer distance units)
//   beta              unsigned inverse temperature, Q(BW-FRAC).FRAC
//   r_metropolis      32-bit uniform random draw
//   clr_cnt           synchronous clear of accept_cnt
//   busy              decision in progress (not asserted in the result cycle)
//   valid             one-cycle result strobe
//   accept            decision, held until the next valid
//   accept_cnt        wrapping count of accepted decisions
module metropolis_judge #(
    parameter int unsigned DW   = 24,
    parameter int unsigned BW   = 16,
    parameter int unsigned FRAC = 12,
    parameter int unsigned XW   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic signed [DW-1:0] delta_dist,
    input  logic        [BW-1:0] beta,
    input  logic        [31:0]   r_metropolis,
    input  logic                 clr_cnt,
    output logic                 busy,
    output logic                 valid,
    output logic                 accept,
    output logic        [31:0]   accept_cnt
);

    localparam int unsigned RW  = 32;                 // random word width
    localparam int unsigned LW  = 18;                 // -ln(r) width, Q.FRAC
    localparam int unsigned CW  = $clog2(BW + 1);     // iteration counter width
    localparam int unsigned MW  = DW - 1;             // magnitude of positive delta
    localparam int unsigned PW  = XW + 2;             // headroom for 2x + delta
    // round(ln2 * 2^FRAC); the LUT below is likewise tabulated for FRAC = 12
    localparam int unsigned LN2 = 2839;
    localparam logic [XW-1:0] XMAX = {XW{1'b1}};

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        LOG,
        CMP,
        DONE
    } state_e;

    state_e          state_q, state_d;
    logic [MW-1:0]   mag_q, mag_d;
    logic [BW-1:0]   beta_q, beta_d;
    logic [RW-1:0]   r_q, r_d;
    logic [XW-1:0]   x_q, x_d;
    logic [CW-1:0]   iter_q, iter_d;
    logic [LW-1:0]   nlog_q, nlog_d;
    logic            inf_q, inf_d;
    logic            accept_q, accept_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;
    logic [31:0]     accept_cnt_q, accept_cnt_d;

    logic [PW-1:0]   mul_sum;
    logic [4:0]      lz_c;
    logic            found_c;
    logic [RW-1:0]   norm_c;
    logic [3:0]      f_c;
    logic [LW-1:0]   nlog_c;

    // round(ln(1 + i/16) * 2^12)
    function automatic logic [LW-1:0] ln_lut(input logic [3:0] i);
        logic [LW-1:0] v;
        case (i)
            4'd0:    v = LW'(0);
            4'd1:    v = LW'(248);
            4'd2:    v = LW'(482);
            4'd3:    v = LW'(704);
            4'd4:    v = LW'(914);
            4'd5:    v = LW'(1114);
            4'd6:    v = LW'(1304);
            4'd7:    v = LW'(1486);
            4'd8:    v = LW'(1661);
            4'd9:    v = LW'(1828);
            4'd10:   v = LW'(1989);
            4'd11:   v = LW'(2143);
            4'd12:   v = LW'(2292);
            4'd13:   v = LW'(2436);
            4'd14:   v = LW'(2575);
            default: v = LW'(2709);
        endcase
        return v;
    endfunction

    // -ln(r/2^32) = (lz+1)*ln2 - ln(1.f); normalising r puts f just below bit 31
    always_comb begin
        lz_c    = '0;
        found_c = 1'b0;
        for (int i = RW - 1; i >= 0; i--) begin
            if (!found_c && r_q[i]) begin
                lz_c    = 5'(RW - 1 - i);
                found_c = 1'b1;
            end
        end
        norm_c = r_q << lz_c;
        f_c    = 4'(norm_c >> (RW - 5));
        nlog_c = LW'((32'(lz_c) + 32'd1) * 32'(LN2)) - ln_lut(f_c);
    end

    // Next-state and datapath
    always_comb begin
        state_d  = state_q;
        mag_d    = mag_q;
        beta_d   = beta_q;
        r_d      = r_q;
        x_d      = x_q;
        iter_d   = iter_q;
        nlog_d   = nlog_q;
        inf_d    = inf_q;
        accept_d = accept_q;
        mul_sum  = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mag_d  = delta_dist[MW-1:0];
                    beta_d = beta;
                    r_d    = r_metropolis;
                    if (delta_dist[DW-1] || (delta_dist == '0)) begin
                        state_d  = DONE;
                        accept_d = 1'b1;
                    end else begin
                        state_d = MUL;
                        x_d     = '0;
                        iter_d  = CW'(BW);
                    end
                end
            end
            MUL: begin
                // MSB-first: x = 2x + bit*delta; saturation is sticky since 2*XMAX > XMAX
                mul_sum = PW'({x_q, 1'b0}) + (beta_q[BW-1] ? PW'(mag_q) : '0);
                x_d     = (mul_sum > PW'(XMAX)) ? XMAX : XW'(mul_sum);
                beta_d  = beta_q << 1;
                iter_d  = iter_q - CW'(1);
                if (iter_d == '0) begin
                    state_d = LOG;
                end
            end
            LOG: begin
                nlog_d  = nlog_c;
                inf_d   = (r_q == '0);
                state_d = CMP;
            end
            CMP: begin
                accept_d = inf_q | (x_q < XW'(nlog_q));
                state_d  = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered strobes; the count bumps on entry to DONE so it is current with valid
    always_comb begin
        valid_d = (state_d == DONE);
        busy_d  = (state_d == MUL) || (state_d == LOG) || (state_d == CMP);
        if (clr_cnt) begin
            accept_cnt_d = '0;
        end else if ((state_d == DONE) && accept_d) begin
            accept_cnt_d = accept_cnt_q + 32'd1;
        end else begin
            accept_cnt_d = accept_cnt_q;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            mag_q        <= '0;
            beta_q       <= '0;
            r_q          <= '0;
            x_q          <= '0;
            iter_q       <= '0;
            nlog_q       <= '0;
            inf_q        <= 1'b0;
            accept_q     <= 1'b0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            accept_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            mag_q        <= mag_d;
            beta_q       <= beta_d;
            r_q          <= r_d;
            x_q          <= x_d;
            iter_q       <= iter_d;
            nlog_q       <= nlog_d;
            inf_q        <= inf_d;
            accept_q     <= accept_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            accept_cnt_q <= accept_cnt_d;
        end
    end

    assign busy       = busy_q;
    assign valid      = valid_q;
    assign accept     = accept_q;
    assign accept_cnt = accept_cnt_q;

endmodule

// File: tb/tb_metropolis_judge.sv
// Randomised and directed bench for metropolis_judge against a real-arithmetic
// derived reference of the acceptance rule.
module tb_metropolis_judge;

    localparam int unsigned DW = 24;
    localparam int unsigned BW = 16;
    localparam int SLOW_LAT = BW + 3;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic signed [DW-1:0] delta_dist;
    logic        [BW-1:0] beta;
    logic        [31:0]   r_metropolis;
    logic                 clr_cnt;
    logic                 busy;
    logic                 valid;
    logic                 accept;
    logic        [31:0]   accept_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_cnt = '0;
    logic        model_acc = 1'b0;

    metropolis_judge #(.DW(DW), .BW(BW), .FRAC(12), .XW(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .delta_dist   (delta_dist),
        .beta         (beta),
        .r_metropolis (r_metropolis),
        .clr_cnt      (clr_cnt),
        .busy         (busy),
        .valid        (valid),
        .accept       (accept),
        .accept_cnt   (accept_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned q12(input real v);
        return $rtoi(v * 4096.0 + 0.5);
    endfunction

    // Reference: accept iff delta<=0, r==0, or sat(delta*beta) < (lz+1)ln2 - ln(1+f/16)
    function automatic logic model_accept(input logic signed [DW-1:0] d,
                                          input logic [BW-1:0] b,
                                          input logic [31:0] r);
        longint prod;
        longint nlog;
        int     p;
        longint frac;
        if (d <= 0) return 1'b1;
        prod = longint'(d) * longint'(b);
        if (prod > 64'h0000_0000_FFFF_FFFF) prod = 64'h0000_0000_FFFF_FFFF;
        if (r == 0) return 1'b1;
        p = 31;
        while (r[p] == 1'b0) p--;
        frac = ((longint'(r) - (longint'(1) << p)) * 16) >> p;
        nlog = longint'(32 - p) * longint'(q12($ln(2.0)))
             - longint'(q12($ln(1.0 + real'(frac) / 16.0)));
        return prod < nlog;
    endfunction

    // One complete decision with per-cycle strobe checks; optional clear in the result cycle
    task automatic do_op(input string tag, input logic signed [DW-1:0] d,
                         input logic [BW-1:0] b, input logic [31:0] r, input bit clr);
        int  lat;
        logic acc;
        acc = model_accept(d, b, r);
        lat = (d <= 0) ? 1 : SLOW_LAT;
        delta_dist   = d;
        beta         = b;
        r_metropolis = r;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start        = 1'b0;
        delta_dist   = DW'($urandom);
        beta         = BW'($urandom);
        r_metropolis = $urandom;
        for (int cyc = 1; cyc <= lat; cyc++) begin
            @(negedge clk);
            if (cyc < lat) begin
                check_eq({tag, ".busy"}, 32'(busy), 32'd1);
                check_eq({tag, ".early_valid"}, 32'(valid), 32'd0);
            end
        end
        model_cnt = model_cnt + 32'(acc);
        model_acc = acc;
        check_eq({tag, ".valid"}, 32'(valid), 32'd1);
        check_eq({tag, ".accept"}, 32'(accept), 32'(acc));
        check_eq({tag, ".cnt"}, accept_cnt, model_cnt);
        check_eq({tag, ".busy_done"}, 32'(busy), 32'd0);
        clr_cnt = clr;
        @(negedge clk);
        clr_cnt = 1'b0;
        if (clr) model_cnt = '0;
        check_eq({tag, ".valid_pulse"}, 32'(valid), 32'd0);
        check_eq({tag, ".accept_hold"}, 32'(accept), 32'(acc));
        check_eq({tag, ".cnt_after"}, accept_cnt, model_cnt);
    endtask

    initial begin
        int pulses;
        int pulse_cyc;
        logic acc;
        logic signed [DW-1:0] rd;
        logic [31:0] rr;

        reset = 1'b1;
        start = 1'b0;
        clr_cnt = 1'b0;
        delta_dist = '0;
        beta = '0;
        r_metropolis = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst.busy", 32'(busy), 32'd0);
        check_eq("rst.valid", 32'(valid), 32'd0);
        check_eq("rst.accept", 32'(accept), 32'd0);
        check_eq("rst.cnt", accept_cnt, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        do_op("fast_zero", 24'sd0, 16'd4096, $urandom, 1'b0);
        do_op("fast_neg", -24'sd5, 16'd4096, $urandom, 1'b0);
        do_op("acc_b1", 24'sd1, 16'd4096, 32'h4000_0000, 1'b0);
        do_op("rej_b1", 24'sd1, 16'd4096, 32'h8000_0000, 1'b0);
        do_op("sat_r0", 24'sh7FFFFF, 16'hFFFF, 32'h0, 1'b0);
        do_op("sat_r1", 24'sh7FFFFF, 16'hFFFF, 32'h1, 1'b0);

        for (int n = 0; n < 48; n++) begin
            case ($urandom_range(3, 0))
                0:       rd = -DW'($urandom_range(100, 0));
                1:       rd = DW'($urandom_range(8, 1));
                2:       rd = DW'($urandom_range(40, 1));
                default: rd = {1'b0, 23'($urandom)};
            endcase
            rr = $urandom >> $urandom_range(31, 0);
            if ($urandom_range(15, 0) == 0) rr = '0;
            do_op("rand", rd, BW'($urandom_range(8192, 0)), rr, $urandom_range(7, 0) == 0);
        end

        // A second start mid-decision must neither restart nor queue
        acc = model_accept(24'sd3, 16'd2048, 32'h0123_4567);
        delta_dist = 24'sd3; beta = 16'd2048; r_metropolis = 32'h0123_4567;
        start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        pulses = 0; pulse_cyc = 0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            start = (cyc == 4);
            delta_dist = (cyc == 4) ? 24'sd0 : delta_dist;
            if (valid) begin
                pulses++;
                pulse_cyc = cyc;
                if (pulses == 1) check_eq("dbl.accept", 32'(accept), 32'(acc));
            end
        end
        start = 1'b0;
        model_cnt = model_cnt + 32'(acc);
        check_eq("dbl.pulses", 32'(pulses), 32'd1);
        check_eq("dbl.latency", 32'(pulse_cyc), 32'(SLOW_LAT));
        check_eq("dbl.cnt", accept_cnt, model_cnt);

        // Clear coincident with an accepting decision
        do_op("clr_acc", 24'sd0, 16'd100, 32'h5, 1'b1);

        // Wrap of the accept counter from all-ones
        @(negedge clk);
        force dut.accept_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.accept_cnt_q;
        model_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        check_eq("wrap.preload", accept_cnt, 32'hFFFF_FFFF);
        do_op("wrap", -24'sd1, 16'd1, 32'h7, 1'b0);

        // Reset in the middle of a slow decision
        delta_dist = 24'sd9; beta = 16'd300; r_metropolis = 32'h00F0_0000;
        start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        pulses = 0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (valid) pulses++;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_cnt = '0;
        check_eq("rst_mid.busy", 32'(busy), 32'd0);
        check_eq("rst_mid.cnt", accept_cnt, 32'd0);
        check_eq("rst_mid.accept", 32'(accept), 32'd0);
        for (int cyc = 0; cyc < 25; cyc++) begin
            @(negedge clk);
            if (valid) pulses++;
        end
        check_eq("rst_mid.no_valid", 32'(pulses), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
